// File: rtl/rv_muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide datapath: operation codes,
// divide sequencer states and the machine word width.
package rv_muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_restoring_step.sv
// One iteration of a restoring divider: shift {rem,quo} left, trial-subtract
// the divisor and keep the difference when it does not go negative.
module div_restoring_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    assign shifted = {rem, quo[XLEN-1]};
    // rem < divisor on entry, so whenever shifted overflows XLEN bits the
    // difference still fits and trial[XLEN] is a valid borrow flag.
    assign trial   = shifted - {1'b0, divisor};

    always_comb begin
        if (!trial[XLEN]) begin
            rem_next = trial[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = shifted[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_div_sequencer.sv
// EX-stage sequencer for DIV/DIVU/REM/REMU: 32-step restoring divide with
// sign fix-up, pipeline stall request and a one-cycle result strobe.
module ex_div_sequencer #(
    parameter int XLEN  = rv_muldiv_pkg::XLEN,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] Alu_in1,
    input  logic [XLEN-1:0] Alu_in2,
    input  logic            flush,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] div_result
);

    import rv_muldiv_pkg::*;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    div_state_e      state, state_next;
    div_op_e         op_q;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] rem, quo, divisor;
    logic [XLEN-1:0] rem_step, quo_step;
    logic [XLEN-1:0] result_q;
    logic            neg_q, neg_r;

    // Decode of the incoming instruction, only meaningful in IDLE.
    logic            in_signed, in_rem, in_div_zero, in_ovf, in_fast, accept;
    logic [XLEN-1:0] abs_a, abs_b, fast_result;

    assign in_signed   = ~div_op[0];
    assign in_rem      = div_op[1];
    assign in_div_zero = (Alu_in2 == '0);
    assign in_ovf      = in_signed && (Alu_in1 == MIN_NEG) && (Alu_in2 == '1);
    assign in_fast     = in_div_zero | in_ovf;
    assign abs_a       = (in_signed && Alu_in1[XLEN-1]) ? -Alu_in1 : Alu_in1;
    assign abs_b       = (in_signed && Alu_in2[XLEN-1]) ? -Alu_in2 : Alu_in2;
    assign fast_result = in_div_zero ? (in_rem ? Alu_in1 : '1)
                                     : (in_rem ? '0 : MIN_NEG);

    div_restoring_step #(.XLEN(XLEN)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    accept     = 1'b1;
                    state_next = in_fast ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush)                 state_next = IDLE;
                else if (cnt == LAST_CNT)  state_next = FIX;
            end
            FIX:     state_next = flush ? IDLE : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= DIV_OP_DIV;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= div_op_e'(div_op);
                        cnt     <= '0;
                        rem     <= '0;
                        quo     <= abs_a;
                        divisor <= abs_b;
                        neg_q   <= in_signed && (Alu_in1[XLEN-1] ^ Alu_in2[XLEN-1]);
                        neg_r   <= in_signed && Alu_in1[XLEN-1];
                        if (in_fast) result_q <= fast_result;
                    end
                end
                CALC: begin
                    if (!flush) begin
                        rem <= rem_step;
                        quo <= quo_step;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                FIX: begin
                    if (!flush) begin
                        if (op_q == DIV_OP_REM || op_q == DIV_OP_REMU)
                            result_q <= neg_r ? -rem : rem;
                        else
                            result_q <= neg_q ? -quo : quo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE) && !flush;
    assign stall_req  = ((state == IDLE) && start && !flush) ||
                        (state == CALC) || (state == FIX);
    assign div_result = result_q;

endmodule

// File: tb/tb_ex_div_sequencer.sv
// Directed bench for ex_div_sequencer: stimulus pushes expected results into
// a scoreboard queue; a negedge monitor pops and compares on every done.
module tb_ex_div_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  div_op = 2'b00;
    logic [31:0] alu_a = '0;
    logic [31:0] alu_b = '0;
    logic        flush = 1'b0;
    logic        stall_req, busy, done;
    logic [31:0] div_result;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01,
                           OP_REM = 2'b10, OP_REMU = 2'b11;

    typedef struct {
        logic [31:0] result;
        int          start_cyc;
        int          latency;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    int   done_cnt = 0;
    int   exp_dones = 0;

    ex_div_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .div_op     (div_op),
        .Alu_in1    (alu_a),
        .Alu_in2    (alu_b),
        .flush      (flush),
        .stall_req  (stall_req),
        .busy       (busy),
        .done       (done),
        .div_result (div_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Monitor: compares every done pulse against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_req) stall_cnt++;
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_result"}, div_result, e.result);
                    check({e.name, "_latency"}, 32'(cyc - e.start_cyc), 32'(e.latency));
                end
            end
        end
    end

    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input bit poke);
        bit finished;
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1; div_op = op; alu_a = a; alu_b = b;
        e.result = exp; e.start_cyc = cyc; e.latency = lat; e.name = name;
        sb.push_back(e);
        exp_dones++;
        stall_cnt = 0;
        @(posedge clk); #1;
        start = 1'b0;
        if (poke) begin
            repeat (2) @(posedge clk);
            #1;
            start = 1'b1; div_op = OP_REMU; alu_a = 32'd5; alu_b = 32'd0;
            @(posedge clk); #1;
            start = 1'b0; alu_a = 32'hDEAD_BEEF; alu_b = 32'h1;
        end
        finished = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin
                finished = 1'b1;
                break;
            end
        end
        check({name, "_completes"}, 32'(finished), 32'd1);
        check({name, "_stall_cycles"}, 32'(stall_cnt), 32'(lat));
        if (sb.size() != 0) begin
            check({name, "_done_seen"}, 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    initial begin
        int dones_before;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_result", div_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned normal path
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b0);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 34, 1'b0);
        // Signed normal path
        run_op("div_m7_2",   OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b0);
        run_op("rem_m7_2",   OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b0);
        run_op("div_7_m2",   OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 1'b0);
        // Divide by zero
        run_op("divu_by0",   OP_DIVU, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
        run_op("rem_by0",    OP_REM, 32'd5, 32'd0, 32'd5, 1, 1'b0);
        // Signed overflow
        run_op("div_ovf",    OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
        run_op("rem_ovf",    OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
        // Same operands unsigned take the full iteration path
        run_op("remu_big",   OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 1'b0);
        run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 1'b0);
        run_op("div_min_1",  OP_DIV, 32'h8000_0000, 32'd1, 32'h8000_0000, 34, 1'b0);
        run_op("rem_m100_m7", OP_REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 34, 1'b0);

        // Flush ten cycles into CALC
        dones_before = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; div_op = OP_DIVU; alu_a = 32'd1000; alu_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("flush_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy_after", 32'(busy), 32'd0);
        check("flush_stall_after", 32'(stall_req), 32'd0);
        repeat (40) @(posedge clk);
        check("flush_no_done", 32'(done_cnt), 32'(dones_before));
        run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 34, 1'b0);

        // Start while busy is ignored
        run_op("divu_poke", OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b1);

        // Asynchronous reset mid-CALC
        @(posedge clk); #1;
        start = 1'b1; div_op = OP_DIVU; alu_a = 32'd100; alu_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check("mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_stall", 32'(stall_req), 32'd0);
        check("mid_rst_result", div_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("divu_after_rst", OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b0);

        repeat (5) @(posedge clk);
        check("total_dones", 32'(done_cnt), 32'(exp_dones));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

endmodule
